// File: rtl/pio_edge_poller_pkg.sv
// -----------------------------------------------------------------------------
// pio_poll_pkg
// Shared definitions for the PIO edge poller: FSM state encoding, the two PIO
// register addresses it touches, the slave read latency the FSM is built
// around, and a helper that maps an FSM state to the Avalon control signals
// driven while the FSM sits in that state.
// -----------------------------------------------------------------------------
package pio_poll_pkg;

  // Poller FSM states, in the order a serviced poll walks through them.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_EC   = 3'd1,
    CHK_EC  = 3'd2,
    CLR     = 3'd3,
    RD_LVL  = 3'd4,
    CAP_LVL = 3'd5
  } state_e;

  // PIO register map: live input level and edge-capture flag.
  localparam logic [1:0] PIO_ADDR_DATA = 2'd0;
  localparam logic [1:0] PIO_ADDR_EDGE = 2'd3;

  // The slave registers readdata; the FSM samples one state after the read.
  localparam int unsigned PIO_RD_LATENCY = 32'd1;

  // Avalon control signals belonging to one FSM state.
  typedef struct packed {
    logic [1:0] address;
    logic       chipselect;
    logic       write_n;
  } bus_ctl_t;

  // Bus control for a state; anything not listed is bus-idle on the data address.
  function automatic bus_ctl_t bus_ctl_for(input state_e s);
    bus_ctl_t c;
    c.address    = PIO_ADDR_DATA;
    c.chipselect = 1'b0;
    c.write_n    = 1'b1;
    case (s)
      RD_EC: begin
        c.address    = PIO_ADDR_EDGE;
        c.chipselect = 1'b1;
      end
      CHK_EC: begin
        c.address    = PIO_ADDR_EDGE;
      end
      CLR: begin
        c.address    = PIO_ADDR_EDGE;
        c.chipselect = 1'b1;
        c.write_n    = 1'b0;
      end
      RD_LVL: begin
        c.address    = PIO_ADDR_DATA;
        c.chipselect = 1'b1;
      end
      default: begin
        c.address    = PIO_ADDR_DATA;
      end
    endcase
    return c;
  endfunction

endpackage

// File: rtl/pio_edge_poller_if.sv
// -----------------------------------------------------------------------------
// pio_edge_poller_if
// Avalon-MM link between the edge poller (master) and the PIO slave.
//   address    : register select (0 = data, 3 = edge capture)
//   chipselect : transfer valid
//   write_n    : active-low write strobe
//   writedata  : write payload (the poller always writes zero)
//   readdata   : registered slave read data, valid one cycle after the read
// -----------------------------------------------------------------------------
interface pio_edge_poller_if;

  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );

endinterface

// File: rtl/pio_edge_poller.sv
// -----------------------------------------------------------------------------
// pio_edge_poller
// Autonomous Avalon-MM initiator that polls an edge-capturing PIO. Every
// POLL_CYCLES idle cycles it reads the edge-capture register; when an edge is
// pending it clears it, reads the live level, then pulses event_pulse for one
// cycle and bumps event_count.
//   clk, reset_n : clock, asynchronous active-low reset
//   enable       : polling enable, only looked at while idle
//   bus          : Avalon-MM master port to the PIO slave
//   event_pulse  : one-cycle pulse per serviced edge
//   level        : PIO input level captured at the last serviced edge
//   event_count  : serviced edges, wraps modulo 2^CNT_W
//   busy         : high whenever the FSM is not idle
// -----------------------------------------------------------------------------
module pio_edge_poller
  import pio_poll_pkg::*;
#(
  parameter int unsigned POLL_CYCLES = 16,
  parameter int unsigned CNT_W       = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 enable,
  pio_edge_poller_if.master    bus,
  output logic                 event_pulse,
  output logic                 level,
  output logic [CNT_W-1:0]     event_count,
  output logic                 busy
);

  // Elaboration guards: the timer is 16 bits and the FSM assumes one-cycle reads.
  if ((POLL_CYCLES < 1) || (POLL_CYCLES > 65535)) begin : g_bad_poll_cycles
    $error("pio_edge_poller: POLL_CYCLES must be within 1..65535");
  end
  if (PIO_RD_LATENCY != 1) begin : g_bad_rd_latency
    $error("pio_edge_poller: FSM requires a PIO read latency of 1");
  end

  localparam logic [15:0] TMR_LAST = 16'(POLL_CYCLES - 1);

  state_e      state_q, state_d;
  logic [15:0] timer_q, timer_d;
  bus_ctl_t    ctl_d;

  logic [1:0]       address_q;
  logic             chipselect_q;
  logic             write_n_q;
  logic             event_pulse_q;
  logic             level_q;
  logic [CNT_W-1:0] event_count_q;
  logic             busy_q;

  // Only bit 0 of the PIO registers carries information.
  logic [30:0] rd_unused_s;
  assign rd_unused_s = bus.readdata[31:1];

  // Next state and interval timer.
  always_comb begin
    state_d = state_q;
    timer_d = 16'd0;
    case (state_q)
      IDLE: begin
        if (enable) begin
          if (timer_q == TMR_LAST) begin
            state_d = RD_EC;
            timer_d = 16'd0;
          end else begin
            timer_d = timer_q + 16'd1;
          end
        end else begin
          timer_d = 16'd0;
        end
      end
      RD_EC:   state_d = CHK_EC;
      CHK_EC: begin
        // readdata now holds the edge-capture flag requested in RD_EC.
        if (bus.readdata[0]) begin
          state_d = CLR;
        end else begin
          state_d = IDLE;
        end
      end
      CLR:     state_d = RD_LVL;
      RD_LVL:  state_d = CAP_LVL;
      CAP_LVL: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered so each bus
  // pattern appears exactly while the FSM occupies the matching state.
  assign ctl_d = bus_ctl_for(state_d);

  // State, timer and registered bus/status outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      timer_q       <= 16'd0;
      address_q     <= PIO_ADDR_DATA;
      chipselect_q  <= 1'b0;
      write_n_q     <= 1'b1;
      event_pulse_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      address_q     <= ctl_d.address;
      chipselect_q  <= ctl_d.chipselect;
      write_n_q     <= ctl_d.write_n;
      event_pulse_q <= (state_d == CAP_LVL);
      busy_q        <= (state_d != IDLE);
    end
  end

  // Level capture and event counter, updated as CAP_LVL ends.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      level_q       <= 1'b0;
      event_count_q <= {CNT_W{1'b0}};
    end else if (state_q == CAP_LVL) begin
      level_q       <= bus.readdata[0];
      event_count_q <= event_count_q + CNT_W'(1);
    end
  end

  assign bus.address    = address_q;
  assign bus.chipselect = chipselect_q;
  assign bus.write_n    = write_n_q;
  assign bus.writedata  = 32'd0;

  assign event_pulse = event_pulse_q;
  assign level       = level_q;
  assign event_count = event_count_q;
  assign busy        = busy_q;

endmodule
